// File: rtl/imem_load_sink_pkg.sv
// Shared definitions for the instruction-memory load sink: FSM state encodings
// and the default instruction-memory word-address width.
package imem_load_sink_pkg;

    localparam int ADDR_W_DEFAULT = 10;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_LOADING = 2'd1,
        ST_DRAIN   = 2'd2,
        ST_DONE    = 2'd3
    } load_state_e;

endpackage

// File: rtl/imem_load_sink_fifo.sv
// imem_load_fifo: small synchronous FIFO of {word address, instruction} with a
// combinational head and simultaneous push/pop (a pop frees room for a same-edge push).
module imem_load_fifo #(
    parameter int ADDR_W = 10,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push_i,
    input  logic [ADDR_W-1:0] push_addr_i,
    input  logic [31:0]       push_data_i,
    input  logic              pop_i,
    output logic [ADDR_W-1:0] head_addr_o,
    output logic [31:0]       head_data_o,
    output logic              empty_o,
    output logic              full_o
);
    localparam int ENTRY_W = ADDR_W + 32;
    localparam int PTR_W   = $clog2(DEPTH);
    localparam logic [PTR_W:0] PTR_ONE = 1;

    logic [ENTRY_W-1:0] mem [DEPTH];
    logic [PTR_W:0]     wr_ptr_q, rd_ptr_q;
    logic               do_push, do_pop;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                     (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    assign {head_addr_o, head_data_o} = mem[rd_ptr_q[PTR_W-1:0]];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_q[PTR_W-1:0]] <= {push_addr_i, push_data_i};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
        end
    end

endmodule

// File: rtl/imem_load_sink.sv
// Receiving end of the instruction-memory load interface: validates beats, queues them,
// commits them to memory and holds the CPU until drained. Optional IMEM_LOAD_CHECKSUM_EN adds a checksum port.
module imem_load_sink
    import imem_load_sink_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEFAULT,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              no_op_in,
    input  logic [31:0]       pc_in,
    input  logic [31:0]       instruction_in,
    input  logic              session_end,
    input  logic              imem_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_hold,
    output logic              load_done,
    output logic [ADDR_W:0]   word_count,
`ifdef IMEM_LOAD_CHECKSUM_EN
    output logic [31:0]       checksum,
`endif
    output logic              err_misaligned,
    output logic              err_range,
    output logic              err_overflow
);
    load_state_e state_q, state_d;

    logic            fifo_empty, fifo_full;
    logic            beat_valid, misaligned, out_of_range, no_room, accept;
    logic [ADDR_W:0] word_count_q;
    logic            err_misaligned_q, err_range_q, err_overflow_q;

    assign beat_valid   = !no_op_in && (state_q == ST_IDLE || state_q == ST_LOADING);
    assign misaligned   = (pc_in[1:0] != 2'b00);
    assign out_of_range = |pc_in[31:ADDR_W+2];
    // A same-cycle commit frees a slot, so a full queue still takes the beat.
    assign no_room      = fifo_full && !imem_we;
    assign accept       = beat_valid && !misaligned && !out_of_range && !no_room;

    assign imem_we = !fifo_empty && imem_ready;

    imem_load_fifo #(
        .ADDR_W (ADDR_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (accept),
        .push_addr_i (pc_in[ADDR_W+1:2]),
        .push_data_i (instruction_in),
        .pop_i       (imem_we),
        .head_addr_o (imem_addr),
        .head_data_o (imem_wdata),
        .empty_o     (fifo_empty),
        .full_o      (fifo_full)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (session_end)  state_d = ST_DRAIN;
                else if (accept)  state_d = ST_LOADING;
            end
            ST_LOADING: if (session_end) state_d = ST_DRAIN;
            ST_DRAIN:   if (fifo_empty)  state_d = ST_DONE;
            default:    state_d = ST_DONE;
        endcase
    end

    always_comb begin
        cpu_hold  = (state_q == ST_LOADING) || (state_q == ST_DRAIN);
        load_done = (state_q == ST_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_count_q     <= '0;
            err_misaligned_q <= 1'b0;
            err_range_q      <= 1'b0;
            err_overflow_q   <= 1'b0;
        end else begin
            if (imem_we && word_count_q != '1) word_count_q <= word_count_q + 1'b1;
            // Checks are prioritised: only the first failing reason is flagged.
            if (beat_valid && misaligned) err_misaligned_q <= 1'b1;
            if (beat_valid && !misaligned && out_of_range) err_range_q <= 1'b1;
            if (beat_valid && !misaligned && !out_of_range && no_room) err_overflow_q <= 1'b1;
        end
    end

    assign word_count     = word_count_q;
    assign err_misaligned = err_misaligned_q;
    assign err_range      = err_range_q;
    assign err_overflow   = err_overflow_q;

`ifdef IMEM_LOAD_CHECKSUM_EN
    logic [31:0] checksum_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                             checksum_q <= '0;
        else if (imem_we && state_q != ST_DONE) checksum_q <= checksum_q + imem_wdata;
    end

    assign checksum = checksum_q;
`endif

endmodule

// File: tb/tb_imem_load_sink.sv
// Scoreboard bench for imem_load_sink: stimulus pushes expected writes into a queue,
// an independent monitor pops and compares on every imem_we cycle.
module tb_imem_load_sink;
    localparam int ADDR_W = 10;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              no_op_in = 1'b1;
    logic [31:0]       pc_in = '0;
    logic [31:0]       instruction_in = '0;
    logic              session_end = 1'b0;
    logic              imem_ready = 1'b0;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              cpu_hold, load_done;
    logic [ADDR_W:0]   word_count;
    logic              err_misaligned, err_range, err_overflow;
`ifdef IMEM_LOAD_CHECKSUM_EN
    logic [31:0]       checksum;
`endif

    int checks = 0;
    int errors = 0;
    logic [ADDR_W+31:0] sb[$];

    always #5 clk = ~clk;

    imem_load_sink #(.ADDR_W(ADDR_W), .FIFO_DEPTH(4)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .no_op_in       (no_op_in),
        .pc_in          (pc_in),
        .instruction_in (instruction_in),
        .session_end    (session_end),
        .imem_ready     (imem_ready),
        .imem_we        (imem_we),
        .imem_addr      (imem_addr),
        .imem_wdata     (imem_wdata),
        .cpu_hold       (cpu_hold),
        .load_done      (load_done),
        .word_count     (word_count),
`ifdef IMEM_LOAD_CHECKSUM_EN
        .checksum       (checksum),
`endif
        .err_misaligned (err_misaligned),
        .err_range      (err_range),
        .err_overflow   (err_overflow)
    );

    // Monitor: every committed write must match the oldest expected entry.
    always @(negedge clk) begin
        if (rst_n && imem_we) begin
            logic [ADDR_W+31:0] exp_e;
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: got addr=%h data=%h, required no write", imem_addr, imem_wdata);
            end else begin
                exp_e = sb.pop_front();
                if ({imem_addr, imem_wdata} !== exp_e) begin
                    errors++;
                    $display("FAIL write: got addr=%h data=%h, required addr=%h data=%h",
                             imem_addr, imem_wdata, exp_e[ADDR_W+31:32], exp_e[31:0]);
                end else begin
                    $display("write addr=%h data=%h", imem_addr, imem_wdata);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a beat for one cycle; expected writes are queued only for beats meant to be accepted.
    task automatic beat(input logic [31:0] pc, input logic [31:0] instr, input bit expect_write, input bit end_pulse);
        no_op_in       = 1'b0;
        pc_in          = pc;
        instruction_in = instr;
        session_end    = end_pulse;
        if (expect_write) sb.push_back({pc[ADDR_W+1:2], instr});
        tick();
        no_op_in    = 1'b1;
        session_end = 1'b0;
    endtask

    task automatic do_reset();
        rst_n      = 1'b0;
        no_op_in   = 1'b1;
        imem_ready = 1'b0;
        sb.delete();
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        // Reset state
        tick();
        tick();
        check("reset_we", imem_we, 0);
        check("reset_hold", cpu_hold, 0);
        check("reset_done", load_done, 0);
        check("reset_count", word_count, 0);
        check("reset_errs", {err_misaligned, err_range, err_overflow}, 0);
        rst_n = 1'b1;
        tick();

        // Scenario 1: four back-to-back beats, session_end with the last
        imem_ready = 1'b1;
        beat(32'h0, 32'h8C020000, 1, 0);
        check("s1_hold_loading", cpu_hold, 1);
        beat(32'h4, 32'h20080004, 1, 0);
        beat(32'h8, 32'hAD020000, 1, 0);
        beat(32'hC, 32'h08000000, 1, 1);
        check("s1_drain_hold", cpu_hold, 1);
        check("s1_done_early0", load_done, 0);
        tick();
        check("s1_done_early1", load_done, 0);
        tick();
        check("s1_done", load_done, 1);
        check("s1_hold_done", cpu_hold, 0);
        check("s1_count", word_count, 4);
        check("s1_sb_empty", sb.size(), 0);
`ifdef IMEM_LOAD_CHECKSUM_EN
        check("s1_checksum", checksum, 32'h610C0004);
`endif
        beat(32'h10, 32'hDEADBEEF, 0, 0);
        tick();
        check("s1_done_ignores_beat", word_count, 4);
        check("s1_done_no_err", {err_misaligned, err_range, err_overflow}, 0);
        check("s1_still_done", load_done, 1);

        // Scenario 2: misaligned and out-of-range beats are dropped
        do_reset();
        imem_ready = 1'b1;
        beat(32'h6, 32'h11111111, 0, 0);
        check("s2_misaligned", err_misaligned, 1);
        check("s2_idle_after_mis", cpu_hold, 0);
        check("s2_range_clear", err_range, 0);
        beat(32'h1000, 32'h22222222, 0, 0);
        check("s2_range", err_range, 1);
        check("s2_idle_after_range", cpu_hold, 0);
        check("s2_count0", word_count, 0);
        beat(32'hFFC, 32'h33333333, 1, 0);
        check("s2_top_word_loads", cpu_hold, 1);
        tick();
        check("s2_count1", word_count, 1);
        check("s2_no_overflow", err_overflow, 0);

        // Scenario 3: five beats into a stalled 4-deep queue
        do_reset();
        imem_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            beat(32'h10 + 32'(4 * i), 32'hA0000000 + 32'(i), (i < 4), 0);
        end
        check("s3_overflow", err_overflow, 1);
        check("s3_count_stalled", word_count, 0);
        imem_ready = 1'b1;
        repeat (6) tick();
        check("s3_count", word_count, 4);
        check("s3_sb_empty", sb.size(), 0);
        check("s3_misaligned_clear", err_misaligned, 0);

        // Scenario 4: full queue with a same-cycle commit accepts the beat
        do_reset();
        imem_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            beat(32'h40 + 32'(4 * i), 32'hB0000000 + 32'(i), 1, 0);
        end
        imem_ready = 1'b1;
        beat(32'h50, 32'hB0000004, 1, 0);
        check("s4_no_overflow", err_overflow, 0);
        repeat (6) tick();
        check("s4_count", word_count, 5);
        check("s4_sb_empty", sb.size(), 0);

        // Scenario 5: reset with three beats queued
        do_reset();
        imem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            beat(32'h80 + 32'(4 * i), 32'hC0000000 + 32'(i), 1, 0);
        end
        check("s5_hold_before", cpu_hold, 1);
        rst_n      = 1'b0;
        imem_ready = 1'b1;
        sb.delete();
        #1;
        check("s5_we", imem_we, 0);
        check("s5_count", word_count, 0);
        check("s5_hold", cpu_hold, 0);
        check("s5_done", load_done, 0);
        tick();
        rst_n = 1'b1;
        tick();
        check("s5_we_after", imem_we, 0);
        tick();
        check("s5_count_after", word_count, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
